pipe_stall_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage ARM-style pipeline (IF, ID, EXE, MEM, WB).
- Combines three inputs into per-stage register enables and flushes: the hazard unit's freeze, the branch-taken signal from EXE, and a multi-cycle SRAM access handshake from the MEM stage.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Memory-handshake FSM states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Bit positions inside the per-stage enable vector.
  localparam int PC     = 0;
  localparam int IF_ID  = 1;
  localparam int ID_EX  = 2;
  localparam int EX_MEM = 3;
  localparam int MEM_WB = 4;
  localparam int NUM_EN = 5;

  // Width of the MEM_WAIT cycle counter; bounds the usable timeout range.
  localparam int WAIT_W = 16;

  // Default number of unanswered MEM_WAIT cycles before the timeout flag.
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Memory accesses
// stall everything; in an advance cycle a taken branch beats a RAW freeze.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_freeze,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             sram_start,
  output logic             mem_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  state_e              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_nxt;
  logic [NUM_EN-1:0]   en;
  logic                advance;

  // Saturating next value of the MEM_WAIT cycle counter.
  always_comb begin
    wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  end

  // Decode enables/flushes from state and inputs; everything is held low in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    en          = '0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    sram_start  = 1'b0;
    advance     = 1'b0;

    case (state)
      RUN: begin
        if (mem_req) sram_start = 1'b1;
        else         advance    = 1'b1;
      end
      MEM_WAIT: begin
        if (sram_ready) advance = 1'b1;
      end
      default: advance = 1'b0;
    endcase

    if (advance) begin
      if (branch_taken) begin
        en          = '1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (hazard_freeze) begin
        en[ID_EX]   = 1'b1;
        en[EX_MEM]  = 1'b1;
        en[MEM_WB]  = 1'b1;
        flush_id_ex = 1'b1;
      end else begin
        en = '1;
      end
    end

    if (!rst_n) begin
      en          = '0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      sram_start  = 1'b0;
    end
  end

  assign pc_en     = en[PC];
  assign if_id_en  = en[IF_ID];
  assign id_ex_en  = en[ID_EX];
  assign ex_mem_en = en[EX_MEM];
  assign mem_wb_en = en[MEM_WB];
  assign mem_busy  = (state == MEM_WAIT);

  // Memory handshake FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (sram_ready) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt >= TIMEOUT_C) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_if_id),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with small counters and a short timeout.
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb, fl_if, fl_id, start, busy
  localparam logic [8:0] C_OFF    = 9'b00000_00_0_0;
  localparam logic [8:0] C_RUN    = 9'b11111_00_0_0;
  localparam logic [8:0] C_HAZ    = 9'b00111_01_0_0;
  localparam logic [8:0] C_BR     = 9'b11111_11_0_0;
  localparam logic [8:0] C_START  = 9'b00000_00_1_0;
  localparam logic [8:0] C_WAIT   = 9'b00000_00_0_1;
  localparam logic [8:0] C_WADV   = 9'b11111_00_0_1;

  logic clk = 1'b0;
  logic rst_n, hazard_freeze, branch_taken, mem_req, sram_ready, cnt_clr;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic flush_if_id, flush_id_ex, sram_start, mem_busy, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] ctrl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 flush_if_id, flush_id_ex, sram_start, mem_busy};

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hazard_freeze (hazard_freeze),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .sram_ready    (sram_ready),
    .cnt_clr       (cnt_clr),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .sram_start    (sram_start),
    .mem_busy      (mem_busy),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hazard_freeze = 1'b0;
    branch_taken  = 1'b0;
    mem_req       = 1'b0;
    sram_ready    = 1'b0;
    cnt_clr       = 1'b0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hazard_freeze = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
    sram_ready = 1'b1; cnt_clr = 1'b1;
    step(); step();
    n_cmp++; if (ctrl !== C_OFF) begin n_err++; $display("FAIL rst_ctrl got %b want %b", ctrl, C_OFF); end
    n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b want 0", mem_timeout); end
    // Release with only mem_req high: first cycle must issue a start.
    idle_inputs();
    mem_req = 1'b1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_START) begin n_err++; $display("FAIL rel_start got %b want %b", ctrl, C_START); end
    step();
    sram_ready = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_WADV) begin n_err++; $display("FAIL rel_ready got %b want %b", ctrl, C_WADV); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL rel_run got %b want %b", ctrl, C_RUN); end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL rel_stall got %0d want 1", stall_cnt); end
  endtask

  task automatic test_hazard();
    clear_counters();
    hazard_freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ctrl !== C_HAZ) begin n_err++; $display("FAIL haz_ctrl[%0d] got %b want %b", i, ctrl, C_HAZ); end
      step();
    end
    hazard_freeze = 1'b0;
    n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL haz_stall got %0d want 2", stall_cnt); end
    n_cmp++; if (flush_cnt !== 4'd0) begin n_err++; $display("FAIL haz_flush got %0d want 0", flush_cnt); end
  endtask

  task automatic test_branch_hazard();
    clear_counters();
    branch_taken = 1'b1; hazard_freeze = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_BR) begin n_err++; $display("FAIL br_ctrl got %b want %b", ctrl, C_BR); end
    step();
    idle_inputs();
    n_cmp++; if (flush_cnt !== 4'd1) begin n_err++; $display("FAIL br_flush got %0d want 1", flush_cnt); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL br_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_sram_access();
    logic [8:0] exp_c [5];
    exp_c[0] = C_START; exp_c[1] = C_WAIT; exp_c[2] = C_WAIT;
    exp_c[3] = C_WAIT;  exp_c[4] = C_WADV;
    clear_counters();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sram_ready = (i == 4);
      #1;
      n_cmp++; if (ctrl !== exp_c[i]) begin n_err++; $display("FAIL sram_ctrl[%0d] got %b want %b", i, ctrl, exp_c[i]); end
      step();
    end
    idle_inputs();
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL sram_after got %b want %b", ctrl, C_RUN); end
    n_cmp++; if (stall_cnt !== 4'd4) begin n_err++; $display("FAIL sram_stall got %0d want 4", stall_cnt); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL sram_timeout got %b want 0", mem_timeout); end
    // Ready outside MEM_WAIT is ignored.
    sram_ready = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL ready_ign got %b want %b", ctrl, C_RUN); end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    clear_counters();
    mem_req = 1'b1;
    step();                      // start cycle
    sram_ready = 1'b1;           // ready cycle, next LDR already queued
    step();
    sram_ready = 1'b0;
    #1;
    n_cmp++; if (ctrl !== C_START) begin n_err++; $display("FAIL b2b_start got %b want %b", ctrl, C_START); end
    step();
    sram_ready = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_WADV) begin n_err++; $display("FAIL b2b_ready got %b want %b", ctrl, C_WADV); end
    step();
    idle_inputs();
    n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL b2b_stall got %0d want 2", stall_cnt); end
  endtask

  task automatic test_timeout();
    mem_req = 1'b1;
    step();                      // start cycle
    for (int i = 1; i <= 6; i++) begin
      step();                    // one unanswered MEM_WAIT cycle
      n_cmp++;
      if (mem_timeout !== (i >= TIMEOUT)) begin
        n_err++; $display("FAIL tmo_flag[%0d] got %b want %b", i, mem_timeout, (i >= TIMEOUT));
      end
    end
    n_cmp++; if (ctrl !== C_WAIT) begin n_err++; $display("FAIL tmo_wait got %b want %b", ctrl, C_WAIT); end
    sram_ready = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_WADV) begin n_err++; $display("FAIL tmo_adv got %b want %b", ctrl, C_WADV); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (mem_timeout !== 1'b1 || mem_busy !== 1'b0) begin n_err++; $display("FAIL tmo_sticky got %b/%b want 1/0", mem_timeout, mem_busy); end
  endtask

  task automatic test_saturation();
    clear_counters();
    hazard_freeze = 1'b1;
    repeat (20) step();
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_stall got %0d want 15", stall_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL clr_stall got %0d want 0", stall_cnt); end
    step();
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL resume_stall got %0d want 1", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1'b1;
    step();
    n_cmp++; if (ctrl !== C_WAIT) begin n_err++; $display("FAIL mid_wait got %b want %b", ctrl, C_WAIT); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctrl !== C_OFF || mem_timeout !== 1'b0) begin n_err++; $display("FAIL mid_rst got %b/%b want %b/0", ctrl, mem_timeout, C_OFF); end
    mem_req = 1'b0;
    rst_n = 1'b1;
    step();
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL mid_rel got %b want %b", ctrl, C_RUN); end
    mem_req = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_START) begin n_err++; $display("FAIL mid_restart got %b want %b", ctrl, C_START); end
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch_hazard();
    test_sram_access();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
